opb_register_simulink2ppc_bank: RTL and testbench
=================================================

// Module: opb_register_simulink2ppc_bank
// PURPOSE
//  OPB slave that returns user-fabric data to the PPC, the opposite direction of the
//  ppc2simulink control registers. A bank of C_NUM_REGS 32-bit words is captured
//  atomically on a user strobe and held for software reads. Freeze, new-data and
//  overflow status let software read a coherent snapshot. Sits on the OPB next to
//  the snapshot control registers and shares their address window scheme.
// PARAMETERS
//  C_BASEADDR    32'h01010100  first byte address decoded
//  C_HIGHADDR    32'h010101FF  last byte address decoded
//  C_OPB_AWIDTH  32            OPB address width
//  C_OPB_DWIDTH  32            OPB data width
//  C_NUM_REGS    4             captured words (1..16)
// PORTS
//  OPB_Clk       in   1               single clock for bus and user logic
//  OPB_Rst_n     in   1               asynchronous, active-low reset
//  OPB_ABus      in   [0:31]          address
//  OPB_BE        in   [0:3]           byte enables, BE[0] = DBus[0:7] = reg[31:24]
//  OPB_DBus      in   [0:31]          write data, DBus[0] = reg bit 31
//  OPB_RNW       in   1               1 = read
//  OPB_select    in   1               transfer request
//  OPB_seqAddr   in   1               ignored
//  Sl_DBus       out  [0:31]          read data, zero except in the ack cycle
//  Sl_xferAck    out  1               transfer acknowledge
//  Sl_errAck     out  1               tied 0
//  Sl_retry      out  1               tied 0
//  Sl_toutSup    out  1               tied 0
//  user_data_in  in   [32*C_NUM_REGS-1:0]  word k = bits [32k+31:32k]
//  user_valid    in   1               capture strobe, one cycle per sample
//  user_frozen   out  1               mirrors the freeze bit; user may hold off
// BEHAVIOUR
//  Register map, word offset from C_BASEADDR:
//   0..N-1  RO  captured word k
//   N       status: [0] new_data (RO, sticky); [1] freeze (RW);
//           [23:8] overflow count (RO, saturates at 16'hFFFF);
//           write with bit31=1 clears the overflow count; other bits read 0
//   N+1     RO  capture count, 32-bit, wraps to 0
//   >N+1    inside window: acked, reads 0, writes ignored
//  Decode: hit = OPB_select && C_BASEADDR <= ABus <= C_HIGHADDR.
//  FSM IDLE->ACK->IDLE. Hit sampled in IDLE -> ACK next cycle.
//   In ACK: Sl_xferAck=1 for exactly 1 cycle, Sl_DBus = selected word (reads).
//   Latency from select to ack is 1 cycle. No back-to-back ack; a hit is only
//   accepted in IDLE.
//  Writes: commit in the ACK cycle. Status byte-enables apply: freeze needs BE[3],
//   overflow clear needs BE[0].
//  Capture: user_valid && !freeze -> all words loaded next edge, new_data<=1,
//   capture count +1. user_valid && freeze -> no load; overflow +1 (saturating).
//  Status read in ACK clears new_data. A capture in the same cycle wins: new_data
//   stays 1, and the read returns the pre-capture value 0 or 1.
//  Freeze write and user_valid in the same cycle: the capture uses the old freeze value.
//  Overflow-clear write and overflow increment in the same cycle: the result is 1.
//  Reset: all registers, counters and outputs go to 0 and the FSM goes to IDLE.
//   Reset mid-transaction aborts it with no ack.
// TESTING
//  1 reset; user_data_in word0=32'hDEADBEEF, pulse user_valid; read offset 0 ->
//    ack 1 cycle after select, DBus=DEADBEEF; status bit0=1, capture count=1
//  2 read status twice -> first read bit0=1, second read bit0=0; Sl_xferAck high
//    exactly 1 cycle per transfer
//  3 write status 32'h2 (BE=4'hF); pulse user_valid 3x with new data -> words
//    unchanged, overflow=3, user_frozen=1; write 32'h80000002 -> overflow=0
//  4 user_valid in the same cycle as the status-read ack -> new_data=1 after, capture
//    count incremented
//  5 read offset N+5 -> ack, DBus=0; write there -> no register changes; address
//    outside window -> no ack
//  6 assert OPB_Rst_n=0 in the ACK cycle -> xferAck drops asynchronously, all regs 0,
//    next transfer completes normally

Source files
------------

// File: rtl/opb_register_simulink2ppc_bank.sv
// OPB slave exposing a bank of user-captured 32-bit words to the PPC, with
// freeze, new-data and overflow status for coherent software snapshots.
module opb_register_simulink2ppc_bank #(
  parameter logic [31:0] C_BASEADDR   = 32'h01010100,
  parameter logic [31:0] C_HIGHADDR   = 32'h010101FF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter int unsigned C_NUM_REGS   = 4
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        OPB_RNW,
  input  logic                        OPB_select,
  input  logic                        OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
  output logic                        Sl_xferAck,
  output logic                        Sl_errAck,
  output logic                        Sl_retry,
  output logic                        Sl_toutSup,
  input  logic [32*C_NUM_REGS-1:0]    user_data_in,
  input  logic                        user_valid,
  output logic                        user_frozen
);

  localparam int unsigned OFF_W = 30;

  typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [31:0]               abus;
  logic [31:0]               addr_off;
  logic                      hit;
  logic [OFF_W-1:0]          off_q;
  logic                      rnw_q, be_hi_q, be_lo_q, wbit31_q, wbit1_q;
  logic [32*C_NUM_REGS-1:0]  data_q;
  logic                      new_data_q, freeze_q;
  logic [15:0]               ovf_q;
  logic [31:0]               cap_cnt_q;
  logic                      ack_cyc, wr_status, rd_status, capture, ovf_inc, ovf_clr;
  logic [31:0]               rdata;
  logic                      unused_sink;

  assign abus     = OPB_ABus;
  assign addr_off = abus - C_BASEADDR;
  assign hit      = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);

  // Bus handshake state register
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hit) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Transfer attributes are held from acceptance so the ACK cycle does not
  // depend on the master keeping the bus stable.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      off_q    <= '0;
      rnw_q    <= 1'b0;
      be_hi_q  <= 1'b0;
      be_lo_q  <= 1'b0;
      wbit31_q <= 1'b0;
      wbit1_q  <= 1'b0;
    end else if (state_q == ST_IDLE && hit) begin
      off_q    <= addr_off[31:2];
      rnw_q    <= OPB_RNW;
      be_hi_q  <= OPB_BE[0];
      be_lo_q  <= OPB_BE[3];
      wbit31_q <= OPB_DBus[0];
      wbit1_q  <= OPB_DBus[30];
    end
  end

  always_comb begin
    ack_cyc   = (state_q == ST_ACK);
    wr_status = ack_cyc && !rnw_q && (off_q == OFF_W'(C_NUM_REGS));
    rd_status = ack_cyc &&  rnw_q && (off_q == OFF_W'(C_NUM_REGS));
    capture   = user_valid && !freeze_q;
    ovf_inc   = user_valid &&  freeze_q;
    ovf_clr   = wr_status && be_hi_q && wbit31_q;
  end

  // Capture bank and status; a capture beats a status-read clear of new_data
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      data_q     <= '0;
      new_data_q <= 1'b0;
      freeze_q   <= 1'b0;
      ovf_q      <= '0;
      cap_cnt_q  <= '0;
    end else begin
      if (capture) begin
        data_q     <= user_data_in;
        cap_cnt_q  <= cap_cnt_q + 32'd1;
        new_data_q <= 1'b1;
      end else if (rd_status) begin
        new_data_q <= 1'b0;
      end
      if (wr_status && be_lo_q) freeze_q <= wbit1_q;
      if (ovf_clr)                            ovf_q <= {15'd0, ovf_inc};
      else if (ovf_inc && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
    end
  end

  always_comb begin
    rdata = '0;
    if (ack_cyc && rnw_q) begin
      for (int unsigned k = 0; k < C_NUM_REGS; k++) begin
        if (off_q == OFF_W'(k)) rdata = data_q[32*k +: 32];
      end
      if (off_q == OFF_W'(C_NUM_REGS))
        rdata = {8'h00, ovf_q, 6'b000000, freeze_q, new_data_q};
      else if (off_q == OFF_W'(C_NUM_REGS + 1))
        rdata = cap_cnt_q;
    end
  end

  assign Sl_DBus     = rdata;
  assign Sl_xferAck  = ack_cyc;
  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;
  assign user_frozen = freeze_q;

  assign unused_sink = ^{OPB_seqAddr, OPB_BE[1:2], OPB_DBus[1:29], OPB_DBus[31], addr_off[1:0]};

endmodule

// File: tb/tb_opb_register_simulink2ppc_bank.sv
// Directed self-checking bench for the simulink-to-PPC OPB register bank.
module tb_opb_register_simulink2ppc_bank;

  localparam logic [31:0] BASE = 32'h01010100;

  logic         OPB_Clk = 1'b0;
  logic         OPB_Rst_n;
  logic [0:31]  OPB_ABus;
  logic [0:3]   OPB_BE;
  logic [0:31]  OPB_DBus;
  logic         OPB_RNW;
  logic         OPB_select;
  logic         OPB_seqAddr;
  logic [0:31]  Sl_DBus;
  logic         Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
  logic [127:0] user_data_in;
  logic         user_valid;
  logic         user_frozen;

  int checks = 0;
  int errors = 0;

  opb_register_simulink2ppc_bank dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst_n(OPB_Rst_n), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
    .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
    .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck),
    .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
    .user_data_in(user_data_in), .user_valid(user_valid), .user_frozen(user_frozen)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One OPB transfer; optionally pulses user_valid during the ack cycle.
  task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [3:0] be,
                      input logic [31:0] wdata, input logic valid_in_ack,
                      output logic [31:0] rdata, output logic acked, output int lat);
    acked = 1'b0;
    rdata = '0;
    lat   = 0;
    @(negedge OPB_Clk);
    OPB_ABus = addr; OPB_RNW = rnw; OPB_BE = be; OPB_DBus = wdata; OPB_select = 1'b1;
    for (int i = 1; i <= 4 && !acked; i++) begin
      @(posedge OPB_Clk); #1;
      if (Sl_xferAck) begin
        acked = 1'b1;
        lat   = i;
        rdata = Sl_DBus;
      end
    end
    OPB_select = 1'b0;
    if (acked) begin
      if (valid_in_ack) user_valid = 1'b1;
      @(posedge OPB_Clk); #1;
      user_valid = 1'b0;
      chk("ack_width", 32'(Sl_xferAck), 32'd0);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d; logic a; int l;
    xfer(addr, 1'b1, 4'hF, 32'h0, 1'b0, d, a, l);
    chk({tag, "_ack"}, 32'(a), 32'd1);
    chk({tag, "_lat"}, 32'(l), 32'd1);
    chk(tag, d, exp);
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [3:0] be,
                    input logic [31:0] data);
    logic [31:0] d; logic a; int l;
    xfer(addr, 1'b0, be, data, 1'b0, d, a, l);
    chk({tag, "_ack"}, 32'(a), 32'd1);
    chk({tag, "_rdata"}, d, 32'd0);
  endtask

  task automatic pulse_valid();
    @(negedge OPB_Clk); user_valid = 1'b1;
    @(negedge OPB_Clk); user_valid = 1'b0;
  endtask

  localparam logic [31:0] A_W0   = BASE;
  localparam logic [31:0] A_W1   = BASE + 32'd4;
  localparam logic [31:0] A_STAT = BASE + 32'd16;
  localparam logic [31:0] A_CNT  = BASE + 32'd20;
  localparam logic [31:0] A_HOLE = BASE + 32'd36;

  initial begin
    logic [31:0] d; logic a; int l;
    OPB_Rst_n = 1'b0; OPB_ABus = '0; OPB_BE = '0; OPB_DBus = '0; OPB_RNW = 1'b0;
    OPB_select = 1'b0; OPB_seqAddr = 1'b0; user_data_in = '0; user_valid = 1'b0;
    repeat (2) @(posedge OPB_Clk);
    #1;
    chk("rst_ack", 32'(Sl_xferAck), 32'd0);
    chk("rst_dbus", Sl_DBus, 32'd0);
    chk("rst_frozen", 32'(user_frozen), 32'd0);
    chk("rst_tieoffs", 32'({Sl_errAck, Sl_retry, Sl_toutSup}), 32'd0);
    @(negedge OPB_Clk); OPB_Rst_n = 1'b1;

    // Basic capture and readback
    user_data_in = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
    pulse_valid();
    rd("t1_w0", A_W0, 32'hDEADBEEF);
    rd("t1_w1", A_W1, 32'h11111111);
    rd("t1_cnt", A_CNT, 32'd1);

    // new_data is cleared by a status read
    rd("t2_stat1", A_STAT, 32'h00000001);
    rd("t2_stat2", A_STAT, 32'h00000000);

    // Freeze blocks capture and counts overflow
    wr("t3_freeze", A_STAT, 4'hF, 32'h00000002);
    chk("t3_frozen", 32'(user_frozen), 32'd1);
    user_data_in = {32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
    repeat (3) pulse_valid();
    rd("t3_w0", A_W0, 32'hDEADBEEF);
    rd("t3_stat", A_STAT, 32'h00000302);
    wr("t3_clr", A_STAT, 4'hF, 32'h80000002);
    rd("t3_stat_clr", A_STAT, 32'h00000002);
    rd("t3_cnt", A_CNT, 32'd1);
    wr("t3_nobe3", A_STAT, 4'b1110, 32'h00000000);
    rd("t3_stat_be", A_STAT, 32'h00000002);
    wr("t3_unfreeze", A_STAT, 4'hF, 32'h00000000);
    chk("t3_unfrozen", 32'(user_frozen), 32'd0);

    // Capture in the status-read ack cycle wins over the clear
    xfer(A_STAT, 1'b1, 4'hF, 32'h0, 1'b1, d, a, l);
    chk("t4_ack", 32'(a), 32'd1);
    chk("t4_stat_pre", d, 32'h00000000);
    rd("t4_stat_post", A_STAT, 32'h00000001);
    rd("t4_cnt", A_CNT, 32'd2);
    rd("t4_w0", A_W0, 32'h77777777);

    // Unmapped offsets inside the window, and addresses outside it
    rd("t5_hole", A_HOLE, 32'h00000000);
    wr("t5_hole_wr", A_HOLE, 4'hF, 32'hFFFFFFFF);
    rd("t5_w0", A_W0, 32'h77777777);
    rd("t5_stat", A_STAT, 32'h00000000);
    rd("t5_cnt", A_CNT, 32'd2);
    xfer(BASE + 32'h100, 1'b1, 4'hF, 32'h0, 1'b0, d, a, l);
    chk("t5_above_noack", 32'(a), 32'd0);
    xfer(BASE - 32'd4, 1'b1, 4'hF, 32'h0, 1'b0, d, a, l);
    chk("t5_below_noack", 32'(a), 32'd0);

    // Reset during the ack cycle
    @(negedge OPB_Clk);
    OPB_ABus = A_W0; OPB_RNW = 1'b1; OPB_BE = 4'hF; OPB_select = 1'b1;
    @(posedge OPB_Clk); #1;
    chk("t6_ack_before", 32'(Sl_xferAck), 32'd1);
    OPB_Rst_n = 1'b0;
    #1;
    chk("t6_ack_async", 32'(Sl_xferAck), 32'd0);
    chk("t6_dbus_async", Sl_DBus, 32'd0);
    OPB_select = 1'b0;
    @(negedge OPB_Clk);
    @(negedge OPB_Clk); OPB_Rst_n = 1'b1;
    rd("t6_w0", A_W0, 32'h00000000);
    rd("t6_stat", A_STAT, 32'h00000000);
    rd("t6_cnt", A_CNT, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
